// File: rtl/ps2_device_tx.sv
// rtl/ps2_device_tx.sv - device-side PS/2 transmitter (keyboard emulator) with host-inhibit retry
module ps2_device_tx #(
    parameter int HALF_BIT = 2500,
    parameter int IDLE_GAP = 1000
) (
    input  logic       MCLK,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2c_in,
    output logic       PS2C,
    output logic       PS2D,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam int CNT_MAX = (HALF_BIT > IDLE_GAP) ? HALF_BIT : IDLE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        SEND_LO,
        GAP,
        INHIBIT
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          sync1_q, sync2_q;
    logic          ps2c_q, ps2c_d;
    logic          ps2d_q, ps2d_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;
    logic [10:0]   frame_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = 4'd0;
                if (tx_valid) begin
                    data_d  = tx_data;
                    state_d = SEND_HI;
                end
            end
            SEND_HI: begin
                // First few counts are masked: the synchroniser still shows our own low phase.
                if (cnt_q >= CW'(3) && bit_q <= 4'd9 && !sync2_q) begin
                    state_d = INHIBIT;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = SEND_LO;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND_LO: begin
                if (cnt_q == CW'(HALF_BIT - 1)) begin
                    cnt_d = '0;
                    if (bit_q < 4'd10) begin
                        bit_d   = bit_q + 4'd1;
                        state_d = SEND_HI;
                    end else begin
                        state_d = GAP;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (cnt_q == CW'(IDLE_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            INHIBIT: begin
                if (!sync2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CW'(IDLE_GAP - 1)) begin
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                    state_d = SEND_HI;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
            end
        endcase

        // Line levels are registered together with the state so they change only on state entry.
        frame_d = {1'b1, ~^data_d, data_d, 1'b0};
        ps2c_d  = (state_d != SEND_LO);
        if (state_d == SEND_HI) begin
            ps2d_d = frame_d[bit_d];
        end else if (state_d == SEND_LO) begin
            ps2d_d = ps2d_q;
        end else begin
            ps2d_d = 1'b1;
        end
    end

    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            data_q  <= 8'h00;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            ps2c_q  <= 1'b1;
            ps2d_q  <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            sync1_q <= ps2c_in;
            sync2_q <= sync1_q;
            ps2c_q  <= ps2c_d;
            ps2d_q  <= ps2d_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign PS2C     = ps2c_q;
    assign PS2D     = ps2d_q;
    assign tx_done  = done_q;
    assign tx_abort = abort_q;

endmodule

// File: tb/tb_ps2_device_tx.sv
// tb/tb_ps2_device_tx.sv - self-checking bench for ps2_device_tx with a host-side frame decoder
module tb_ps2_device_tx;

    localparam int HB = 8;
    localparam int IG = 20;

    logic       MCLK = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2c_in;
    logic       PS2C, PS2D, busy, tx_done, tx_abort;
    logic       host_pull = 1'b0;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int frames_rx = 0;
    int exp_q[$];

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    vec_t vecs[4];

    ps2_device_tx #(.HALF_BIT(HB), .IDLE_GAP(IG)) dut (
        .MCLK(MCLK), .reset_n(reset_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .ps2c_in(ps2c_in), .PS2C(PS2C), .PS2D(PS2D),
        .busy(busy), .tx_done(tx_done), .tx_abort(tx_abort)
    );

    // Open-collector clock line: either end can pull it low.
    assign ps2c_in = PS2C & ~host_pull;

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int frame_of(input logic [7:0] d);
        return int'({1'b1, ~^d, d, 1'b0});
    endfunction

    // Host decoder: samples PS2D on each PS2C falling edge.
    initial begin
        int   nb;
        logic prev_c;
        logic [10:0] bits;
        nb = 0;
        prev_c = 1'b1;
        bits = '0;
        forever begin
            @(negedge MCLK);
            if (!reset_n) begin
                nb = 0;
                prev_c = 1'b1;
            end else begin
                if (tx_abort) begin
                    nb = 0;
                    abort_cnt++;
                end
                if (tx_done) done_cnt++;
                if (prev_c && !PS2C) begin
                    bits[nb] = PS2D;
                    nb++;
                    if (nb == 11) begin
                        frames_rx++;
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", int'(bits), -1);
                        end else begin
                            check("frame", int'(bits), exp_q.pop_front());
                        end
                        nb = 0;
                    end
                end
                prev_c = PS2C;
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!tx_ready && k < 1000) begin
            @(negedge MCLK);
            k++;
        end
        if (!tx_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] d, output int n0);
        @(negedge MCLK);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        n0 = cyc;
        exp_q.push_back(frame_of(d));
        @(negedge MCLK);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(output int c);
        int k = 0;
        while (!tx_done && k < 1000) begin
            @(negedge MCLK);
            k++;
        end
        c = tx_done ? cyc : -1;
    endtask

    task automatic wait_ready_cyc(output int c);
        int k = 0;
        while (!tx_ready && k < 1000) begin
            @(negedge MCLK);
            k++;
        end
        c = tx_ready ? cyc : -1;
    endtask

    initial begin
        int n0, c, r, d0, a0, gap;
        vecs[0] = '{8'h1C, 11'h438};
        vecs[1] = '{8'h00, 11'h600};
        vecs[2] = '{8'hFF, 11'h7FE};
        vecs[3] = '{8'h01, 11'h402};

        repeat (3) @(negedge MCLK);
        check("rst_ps2c", PS2C, 1);
        check("rst_ps2d", PS2D, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(negedge MCLK);
        check("idle_done_abort", {tx_done, tx_abort}, 0);

        // Table-driven frames: latency of done/ready plus the decoded frame.
        foreach (vecs[i]) begin
            @(negedge MCLK);
            wait_ready();
            tx_data  = vecs[i].data;
            tx_valid = 1'b1;
            n0 = cyc;
            exp_q.push_back(int'(vecs[i].frame));
            @(negedge MCLK);
            tx_valid = 1'b0;
            check("start_bit_low", PS2D, 0);
            wait_done(c);
            check("done_latency", c - n0, 177);
            wait_ready_cyc(c);
            check("ready_latency", c - n0, 197);
        end

        // Host inhibit during bit 4 high phase.
        d0 = done_cnt;
        a0 = abort_cnt;
        send(8'h5A, n0);
        while (cyc < n0 + 68) @(negedge MCLK);
        host_pull = 1'b1;
        c = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge MCLK);
            if (tx_abort && c < 0) begin
                c = cyc;
                check("inhibit_release_lines", {PS2C, PS2D}, 3);
            end
        end
        check("abort_latency", c - (n0 + 68), 3);
        host_pull = 1'b0;
        r = cyc;
        c = -1;
        for (int k = 0; k < 60 && c < 0; k++) begin
            @(negedge MCLK);
            if (!PS2D) c = cyc;
        end
        check("restart_delay", c - r, 2 + IG);
        wait_done(c);
        check("retry_done_latency", c - r, 2 + IG + 176);
        wait_ready();
        check("retry_done_count", done_cnt - d0, 1);
        check("retry_abort_count", abort_cnt - a0, 1);

        // Inhibit during stop-bit high phase is ignored.
        d0 = done_cnt;
        a0 = abort_cnt;
        send(8'h01, n0);
        while (cyc < n0 + 163) @(negedge MCLK);
        host_pull = 1'b1;
        repeat (4) @(negedge MCLK);
        host_pull = 1'b0;
        wait_done(c);
        check("stop_inhibit_done_latency", c - n0, 177);
        wait_ready();
        check("stop_inhibit_abort_count", abort_cnt - a0, 0);
        check("stop_inhibit_done_count", done_cnt - d0, 1);

        // Back-to-back with tx_valid held high.
        @(negedge MCLK);
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        exp_q.push_back(frame_of(8'hF0));
        @(negedge MCLK);
        tx_data = 8'h1C;
        exp_q.push_back(frame_of(8'h1C));
        wait_done(c);
        gap = 0;
        for (int k = 0; k < 100 && PS2D; k++) begin
            if (busy && PS2C && PS2D) gap++;
            @(negedge MCLK);
        end
        tx_valid = 1'b0;
        check("b2b_gap", gap, IG);
        wait_done(c);
        check("b2b_second_done", c > 0, 1);
        wait_ready();

        // Reset mid-frame.
        d0 = done_cnt;
        send(8'hAA, n0);
        repeat (50) @(negedge MCLK);
        reset_n = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge MCLK);
        reset_n = 1'b1;
        @(negedge MCLK);
        check("midrst_lines", {PS2C, PS2D}, 3);
        check("midrst_ready_busy", {tx_ready, busy}, 2);
        repeat (250) @(negedge MCLK);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_idle", tx_ready, 1);

        check("frames_decoded", frames_rx, 8);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
